// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, tick divider helper and the
// widest supported data word.
package uart_pkg;

   localparam int MAX_DATA_BITS = 9;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   // Clocks per oversample tick; never below 1 so the tick is always live
   function automatic int calc_div(input int clk_freq, input int baud, input int os);
      int d;
      d = clk_freq / (baud * os);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-clk pulse every DIV clks, with a synchronous
// clear that restarts the period (used to phase-align to a start edge).
module uart_os_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Free-running period counter, restarted by clr
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled mid-bit
// sampling, false-start rejection, framing/overrun detection and a one-word
// valid/ready holding register.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int TW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(MAX_DATA_BITS + 1);
   localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
   localparam logic          S_LAST = (STOP_BITS == 2);

   // Unsupported configurations elaborate an empty marker block
   generate
      if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 ||
          DATA_BITS > MAX_DATA_BITS || STOP_BITS < 1 || STOP_BITS > 2 ||
          PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
      end
   endgenerate

   rx_state_t              state, state_n;
   logic                   rx_m, rx_s;
   logic [TW-1:0]          tcnt, tcnt_n;
   logic [BW-1:0]          bcnt, bcnt_n;
   logic                   scnt, scnt_n;
   logic [DATA_BITS-1:0]   sh, sh_n;
   logic                   ferr, ferr_n;
   logic                   done, done_n;
   logic                   tclr, tick;
`ifdef UART_RX_PARITY_EN
   logic                   perr, perr_n;
`endif

   uart_os_tick #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (tclr),
      .tick (tick)
   );

   // Two-flop synchroniser; idles high so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // FSM and frame datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         tcnt  <= '0;
         bcnt  <= '0;
         scnt  <= 1'b0;
         sh    <= '0;
         ferr  <= 1'b0;
         done  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr  <= 1'b0;
`endif
      end else begin
         state <= state_n;
         tcnt  <= tcnt_n;
         bcnt  <= bcnt_n;
         scnt  <= scnt_n;
         sh    <= sh_n;
         ferr  <= ferr_n;
         done  <= done_n;
`ifdef UART_RX_PARITY_EN
         perr  <= perr_n;
`endif
      end
   end

   // Next-state: half-period probe of the start bit, then full-period samples
   always_comb begin
      state_n = state;
      tcnt_n  = tcnt;
      bcnt_n  = bcnt;
      scnt_n  = scnt;
      sh_n    = sh;
      ferr_n  = ferr;
      done_n  = 1'b0;
      tclr    = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_n  = perr;
`endif
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               tcnt_n  = '0;
               tclr    = 1'b1;
               ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
               perr_n  = 1'b0;
`endif
            end
         end
         START: begin
            if (tick) begin
               if (tcnt == T_HALF) begin
                  if (rx_s) begin
                     state_n = IDLE;
                  end else begin
                     state_n = DATA;
                     tcnt_n  = '0;
                     bcnt_n  = '0;
                  end
               end else begin
                  tcnt_n = tcnt + TW'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (tcnt == T_FULL) begin
                  tcnt_n = '0;
                  sh_n   = {rx_s, sh[DATA_BITS-1:1]};
                  bcnt_n = bcnt + BW'(1);
                  if (bcnt == B_LAST) begin
                     scnt_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
                     state_n = PARITY;
`else
                     state_n = STOP;
`endif
                  end
               end else begin
                  tcnt_n = tcnt + TW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (tcnt == T_FULL) begin
                  tcnt_n  = '0;
                  perr_n  = rx_s != ((^sh) ^ (PARITY_ODD != 0));
                  state_n = STOP;
               end else begin
                  tcnt_n = tcnt + TW'(1);
               end
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (tcnt == T_FULL) begin
                  tcnt_n = '0;
                  if (!rx_s)
                     ferr_n = 1'b1;
                  if (scnt == S_LAST) begin
                     state_n = IDLE;
                     done_n  = 1'b1;
                  end else begin
                     scnt_n = 1'b1;
                  end
               end else begin
                  tcnt_n = tcnt + TW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Holding register: load on completion if free (or freed this clk), else drop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (done) begin
            if (!rx_valid || rx_ready) begin
               rx_data   <= sh;
               frame_err <= ferr;
               rx_valid  <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity flag travels with the word it belongs to
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         parity_err <= 1'b0;
      else if (done && (!rx_valid || rx_ready))
         parity_err <= perr;
   end
`else
   assign parity_err = 1'b0;
`endif

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 16 MHz clock, 1 Mbaud, 16x oversample
// (one tick per clk, 16 clk per bit). A second instance covers 7 data bits
// with 2 stop bits.
module tb_uart_rx_param;

   localparam int CLKF = 16_000_000;
   localparam int BRATE = 1_000_000;
   localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   // line low at launch -> 2 sync clks -> START; probe after 8 more ticks,
   // then 16 clk per bit up to the stop sample, +1 clk to rx_valid
   localparam int RISE8 = 156 + 16 * PB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, parity_err, overrun, busy;

   logic       rx7 = 1'b1;
   logic       rx_ready7 = 1'b0;
   logic [6:0] rx_data7;
   logic       rx_valid7, frame_err7, parity_err7, overrun7, busy7;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int launch_cyc = 0;

   uart_rx_param #(.CLK_FREQ(CLKF), .BAUD(BRATE), .OVERSAMPLE(OS),
                   .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
      .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
      .overrun(overrun), .busy(busy));

   uart_rx_param #(.CLK_FREQ(CLKF), .BAUD(BRATE), .OVERSAMPLE(OS),
                   .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) dut7 (
      .clk(clk), .rst(rst), .rx(rx7), .rx_data(rx_data7), .rx_valid(rx_valid7),
      .rx_ready(rx_ready7), .frame_err(frame_err7), .parity_err(parity_err7),
      .overrun(overrun7), .busy(busy7));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observation counters for the 8-bit instance, sampled mid-cycle
   logic       prev_v = 1'b0;
   int         acc_cnt = 0, vld_cyc = 0, busy_cyc = 0, ovr_cnt = 0, rise_cyc = 0;
   logic [7:0] acc_data = '0;
   logic       acc_ferr = 1'b0, acc_perr = 1'b0;

   always @(negedge clk) begin
      if (rx_valid) vld_cyc++;
      if (rx_valid && !prev_v) rise_cyc = cyc;
      prev_v = rx_valid;
      if (busy) busy_cyc++;
      if (overrun) ovr_cnt++;
      if (rx_valid && rx_ready) begin
         acc_cnt++;
         acc_data = rx_data;
         acc_ferr = frame_err;
         acc_perr = parity_err;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int tgt, input logic v);
      if (tgt == 0) rx = v;
      else rx7 = v;
   endtask

   // pbit < 0 selects the correct even parity for the data
   task automatic send(input int tgt, input logic [8:0] d, input int nb, input int ns,
                       input logic stopv, input int pbit);
      logic [8:0] m;
      logic       p;
      m = (9'h1 << nb) - 9'h1;
      launch_cyc = cyc;
      drive(tgt, 1'b0);
      wait_clk(16);
      for (int i = 0; i < nb; i++) begin
         drive(tgt, d[i]);
         wait_clk(16);
      end
      if (PB != 0) begin
         p = (pbit < 0) ? ^(d & m) : (pbit != 0);
         drive(tgt, p);
         wait_clk(16);
      end
      for (int s = 0; s < ns; s++) begin
         drive(tgt, stopv);
         wait_clk(16);
      end
      drive(tgt, 1'b1);
      wait_clk(32);
   endtask

   int a0, v0, b0, o0, bd;

   initial begin
      // reset state
      wait_clk(3);
      chk("rst_data", rx_data, 8'h00);
      chk("rst_valid", rx_valid, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_perr", parity_err, 1'b0);
      chk("rst_ovr", overrun, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      wait_clk(4);

      // 1: clean 0xA5, ready high
      rx_ready = 1'b1;
      a0 = acc_cnt; v0 = vld_cyc;
      send(0, 9'h0A5, 8, 1, 1'b1, -1);
      chk("t1_cnt", acc_cnt - a0, 1);
      chk("t1_data", acc_data, 8'hA5);
      chk("t1_ferr", acc_ferr, 1'b0);
      chk("t1_perr", acc_perr, 1'b0);
      chk("t1_vld_width", vld_cyc - v0, 1);
      chk("t1_latency", rise_cyc - launch_cyc, RISE8);

      // 2: 5-clk glitch is a false start
      a0 = acc_cnt; v0 = vld_cyc; b0 = busy_cyc;
      rx = 1'b0;
      wait_clk(5);
      rx = 1'b1;
      wait_clk(40);
      bd = busy_cyc - b0;
      chk("t2_busy_len", (bd >= 1 && bd <= 9), 1'b1);
      chk("t2_no_valid", vld_cyc - v0, 0);
      chk("t2_idle", busy, 1'b0);

      // 3: stop bit low -> frame_err, then clean frame clears it
      send(0, 9'h03C, 8, 1, 1'b0, -1);
      chk("t3_data", acc_data, 8'h3C);
      chk("t3_ferr", acc_ferr, 1'b1);
      send(0, 9'h001, 8, 1, 1'b1, -1);
      chk("t3_data2", acc_data, 8'h01);
      chk("t3_ferr2", acc_ferr, 1'b0);

      // 4: consumer stalled, second frame overruns
      rx_ready = 1'b0;
      a0 = acc_cnt; o0 = ovr_cnt;
      send(0, 9'h011, 8, 1, 1'b1, -1);
      send(0, 9'h022, 8, 1, 1'b1, -1);
      chk("t4_ovr", ovr_cnt - o0, 1);
      chk("t4_held_vld", rx_valid, 1'b1);
      chk("t4_held_data", rx_data, 8'h11);
      chk("t4_no_acc", acc_cnt - a0, 0);
      rx_ready = 1'b1;
      wait_clk(1);
      chk("t4_acc", acc_cnt - a0, 1);
      chk("t4_acc_data", acc_data, 8'h11);
      chk("t4_vld_drop", rx_valid, 1'b0);

`ifdef UART_RX_PARITY_EN
      // 5: even parity, 0x07 has odd weight
      send(0, 9'h007, 8, 1, 1'b1, 0);
      chk("t5_perr_bad", acc_perr, 1'b1);
      chk("t5_data", acc_data, 8'h07);
      send(0, 9'h007, 8, 1, 1'b1, 1);
      chk("t5_perr_ok", acc_perr, 1'b0);
`else
      chk("t5_perr_tied", parity_err, 1'b0);
`endif

      // 6: reset during data bit 4 aborts the frame
      a0 = acc_cnt;
      fork
         send(0, 9'h0FF, 8, 1, 1'b1, -1);
         begin
            wait_clk(16 * 5 + 8);
            rst = 1'b1;
            wait_clk(2);
            rst = 1'b0;
         end
      join
      chk("t6_abort_cnt", acc_cnt - a0, 0);
      chk("t6_abort_vld", rx_valid, 1'b0);
      chk("t6_abort_busy", busy, 1'b0);
      send(0, 9'h05A, 8, 1, 1'b1, -1);
      chk("t6_cnt", acc_cnt - a0, 1);
      chk("t6_data", acc_data, 8'h5A);
      chk("t6_ferr", acc_ferr, 1'b0);

      // 6b: 7 data bits, 2 stop bits
      send(1, 9'h055, 7, 2, 1'b1, -1);
      chk("t6b_vld", rx_valid7, 1'b1);
      chk("t6b_data", rx_data7, 7'h55);
      chk("t6b_ferr", frame_err7, 1'b0);
      chk("t6b_busy", busy7, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receive FSM. It adds:
- an internal oversampling tick divider with mid-bit sampling;
- a 2-flop input synchroniser and false-start rejection;
- configurable data width and stop-bit count;
- framing and overrun detection, plus optional parity;
- a valid/ready output handshake with a one-word holding register.

It sits between the rx pad and the byte consumer (FIFO or register file).

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115_200, line rate in bit/s
OVERSAMPLE, 16, ticks per bit period; must be even and at least 4
DATA_BITS, 8, data bits per frame, 5..9
STOP_BITS, 1, stop bits checked, 1 or 2
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only with UART_RX_PARITY_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx  in  1  serial line, idle high, asynchronous to clk
rx_data  out  DATA_BITS  received word, LSB first on the line
rx_valid  out  1  rx_data and error flags are valid
rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready
frame_err  out  1  stop bit sampled low; qualified by rx_valid
parity_err  out  1  parity mismatch; qualified by rx_valid
overrun  out  1  one-clk pulse: a completed frame was dropped
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - rx_data = 0; rx_valid, frame_err, parity_err, overrun, busy = 0.
  - Synchroniser flops = 1; FSM = IDLE; all counters = 0.
  - Reset asserted mid-frame aborts the frame; nothing is delivered.
- Tick generator:
  - DIV = CLK_FREQ / (BAUD*OVERSAMPLE), integer division, minimum 1.
  - Tick is a one-clk pulse every DIV clks. The divider free-runs and is cleared on the IDLE->START transition.
- rx is registered through 2 flops (rx_s). All sampling uses rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s == 0, go to START and clear the tick counter (tcnt).
  - START: on tick, tcnt++. At tcnt == OVERSAMPLE/2-1, sample rx_s:
    - 1 = false start: return to IDLE, no flags.
    - 0: go to DATA with tcnt = 0 and bit counter (bcnt) = 0.
  - DATA: on tick, tcnt++. At tcnt == OVERSAMPLE-1, shift rx_s into the MSB of the shift register, clear tcnt, bcnt++.
    - After DATA_BITS samples, go to PARITY if enabled, else to STOP.
  - PARITY: sample after one bit period. parity_calc = XOR(data) ^ PARITY_ODD. Mismatch sets a local perr.
  - STOP: sample STOP_BITS times at one-bit-period spacing. Any low sample sets a local ferr.
    - The last stop sample ends the frame and returns to IDLE in the same clk.
    - The next frame's start bit is accepted immediately.
- Completion (the clk after the last stop sample):
  - If the holding register is free (rx_valid == 0, or rx_valid && rx_ready this clk): load rx_data, frame_err = ferr, parity_err = perr; set rx_valid = 1.
  - Otherwise pulse overrun for 1 clk. The new word is discarded and the held word and flags are unchanged.
- Handshake:
  - rx_valid stays high until rx_valid && rx_ready.
  - rx_ready asserted with rx_valid low has no effect.
  - Acceptance and a new completion in the same clk: the new word is loaded and rx_valid stays 1.
- Frames with ferr are still delivered, with frame_err = 1. No break detection.
- Latency: rx_valid rises 1 clk after the final stop-bit sample.

Optional Feature:
UART_RX_PARITY_EN.
- Defined: the PARITY state exists and one parity bit follows the data bits. parity_err is reported as above.
- Undefined: no PARITY state, frame length = 1 + DATA_BITS + STOP_BITS, and parity_err is tied to 0.

Decomposition:
- Shared package uart_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP};
  - function calc_div(clk_freq, baud, os);
  - localparam MAX_DATA_BITS = 9.
- One sub-module, uart_os_tick (divider with a synchronous clear). It is reused by the future transmitter.
- Synchroniser and FSM stay inline.

Test Plan:
(All cases: CLK_FREQ = 16_000_000, BAUD = 1_000_000, OVERSAMPLE = 16, so DIV = 1 and a bit period is 16 clk.)
1. Frame 0xA5, 8N1, rx_ready held high -> rx_data = 0xA5, rx_valid high for 1 clk, frame_err = 0, rising exactly 1 clk after the stop mid-sample.
2. 5-clk low glitch on idle rx -> returns to IDLE, rx_valid never asserts, busy high for ≤ 9 clk.
3. Frame 0x3C with stop bit driven low -> rx_data = 0x3C, frame_err = 1. The next clean frame 0x01 gives frame_err = 0.
4. rx_ready = 0, frames 0x11 then 0x22 back-to-back -> rx_data stays 0x11 and overrun pulses once. Raise rx_ready -> 0x11 is accepted and rx_valid drops.
5. UART_RX_PARITY_EN, PARITY_ODD = 0, frame 0x07 with parity bit 0 -> parity_err = 1. With parity bit 1 -> parity_err = 0.
6. Assert rst at data bit 4 of frame 0xFF, then send 0x5A -> no output for 0xFF, rx_data = 0x5A delivered cleanly. DATA_BITS = 7, STOP_BITS = 2 variant, 0x55 -> rx_data = 0x55.
